// File: rtl/ahblite_busmatrix_outputstage_2m.sv
// AHB-Lite bus matrix output stage for one slave port shared by two masters
// (M0 = core system bus, M1 = DMAC). Arbitrates each address phase
// round-robin, holds ownership across bursts and locked sequences, steers the
// owner's address/control and write data to the slave, and routes the slave
// response back to whichever master owns the data phase.
module ahblite_busmatrix_outputstage_2m #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  // Master 0 side
  input  logic                  HSEL_M0,
  input  logic [ADDR_WIDTH-1:0] HADDR_M0,
  input  logic [1:0]            HTRANS_M0,
  input  logic                  HWRITE_M0,
  input  logic [2:0]            HSIZE_M0,
  input  logic [3:0]            HPROT_M0,
  input  logic                  HMASTLOCK_M0,
  input  logic [DATA_WIDTH-1:0] HWDATA_M0,
  // Master 1 side
  input  logic                  HSEL_M1,
  input  logic [ADDR_WIDTH-1:0] HADDR_M1,
  input  logic [1:0]            HTRANS_M1,
  input  logic                  HWRITE_M1,
  input  logic [2:0]            HSIZE_M1,
  input  logic [3:0]            HPROT_M1,
  input  logic                  HMASTLOCK_M1,
  input  logic [DATA_WIDTH-1:0] HWDATA_M1,
  // Back to the master-side decoders
  output logic                  ACTIVE_M0,
  output logic                  ACTIVE_M1,
  output logic                  HREADYOUT_M0,
  output logic                  HREADYOUT_M1,
  output logic [1:0]            HRESP_OUT,
  output logic [DATA_WIDTH-1:0] HRDATA_OUT,
  // Slave side
  output logic                  HSEL_S,
  output logic [ADDR_WIDTH-1:0] HADDR_S,
  output logic [1:0]            HTRANS_S,
  output logic                  HWRITE_S,
  output logic [2:0]            HSIZE_S,
  output logic [3:0]            HPROT_S,
  output logic                  HMASTLOCK_S,
  output logic [DATA_WIDTH-1:0] HWDATA_S,
  output logic                  HREADY_S,
  input  logic                  HREADYOUT_S,
  input  logic [1:0]            HRESP_S,
  input  logic [DATA_WIDTH-1:0] HRDATA_S
);

  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_BUSY = 2'b01;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  owner_e r_addr_owner;  // master whose address phase the slave saw last cycle
  owner_e r_data_owner;  // master whose data phase is in progress
  logic   r_last_win;    // 0 = M0 won last arbitration, 1 = M1

  owner_e w_owner;       // address-phase owner this cycle
  logic   w_req_m0;
  logic   w_req_m1;
  logic   w_hold_m0;
  logic   w_hold_m1;
  logic   w_hready_s;

  assign w_req_m0 = HSEL_M0 & HTRANS_M0[1];
  assign w_req_m1 = HSEL_M1 & HTRANS_M1[1];

  // The current owner keeps the slot while it is mid-burst (BUSY/SEQ) or
  // locked; dropping HSEL or presenting IDLE/NONSEQ unlocked releases it.
  assign w_hold_m0 = (r_addr_owner == OWN_M0) & HSEL_M0 &
                     ((HTRANS_M0 == TRANS_BUSY) | (HTRANS_M0 == TRANS_SEQ) | HMASTLOCK_M0);
  assign w_hold_m1 = (r_addr_owner == OWN_M1) & HSEL_M1 &
                     ((HTRANS_M1 == TRANS_BUSY) | (HTRANS_M1 == TRANS_SEQ) | HMASTLOCK_M1);

  // With no data phase outstanding the slave is implicitly ready.
  assign w_hready_s = (r_data_owner == OWN_NONE) ? 1'b1 : HREADYOUT_S;
  assign HREADY_S   = w_hready_s;

  // Address-phase arbitration: zero-latency, frozen while the slave stalls.
  always_comb begin
    // NOTE: default assignment first so every path drives w_owner and no latch is inferred.
    w_owner = OWN_NONE;
    if (!HRESETn) begin
      // Keep the slave and decoders idle while reset is held, even if a
      // master is still driving a request.
      w_owner = OWN_NONE;
    end else if (!w_hready_s) begin
      w_owner = r_addr_owner;
    end else if (w_hold_m0) begin
      w_owner = OWN_M0;
    end else if (w_hold_m1) begin
      w_owner = OWN_M1;
    end else if (r_last_win) begin
      if (w_req_m0)      w_owner = OWN_M0;
      else if (w_req_m1) w_owner = OWN_M1;
    end else begin
      if (w_req_m1)      w_owner = OWN_M1;
      else if (w_req_m0) w_owner = OWN_M0;
    end
  end

  assign ACTIVE_M0 = (w_owner == OWN_M0);
  assign ACTIVE_M1 = (w_owner == OWN_M1);

  // Steer the owner's address/control to the slave; idle when unowned.
  always_comb begin
    HSEL_S      = 1'b0;
    HADDR_S     = '0;
    HTRANS_S    = TRANS_IDLE;
    HWRITE_S    = 1'b0;
    HSIZE_S     = '0;
    HPROT_S     = '0;
    HMASTLOCK_S = 1'b0;
    case (w_owner)
      OWN_M0: begin
        HSEL_S      = HSEL_M0;
        HADDR_S     = HADDR_M0;
        HTRANS_S    = HTRANS_M0;
        HWRITE_S    = HWRITE_M0;
        HSIZE_S     = HSIZE_M0;
        HPROT_S     = HPROT_M0;
        HMASTLOCK_S = HMASTLOCK_M0;
      end
      OWN_M1: begin
        HSEL_S      = HSEL_M1;
        HADDR_S     = HADDR_M1;
        HTRANS_S    = HTRANS_M1;
        HWRITE_S    = HWRITE_M1;
        HSIZE_S     = HSIZE_M1;
        HPROT_S     = HPROT_M1;
        HMASTLOCK_S = HMASTLOCK_M1;
      end
      default: ;
    endcase
  end

  // Ownership state: address owner every cycle, data owner and round-robin
  // pointer only on an HREADY boundary.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_addr_owner <= OWN_NONE;
      r_data_owner <= OWN_NONE;
      r_last_win   <= 1'b1;  // M0 wins the first tie
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      r_addr_owner <= w_owner;
      if (w_hready_s) begin
        r_data_owner <= (HSEL_S & HTRANS_S[1]) ? w_owner : OWN_NONE;
        if (w_owner != OWN_NONE) begin
          r_last_win <= (w_owner == OWN_M1);
        end
      end
    end
  end

  // Data-phase routing: write data from, and response to, the data owner.
  always_comb begin
    HWDATA_S     = '0;
    HREADYOUT_M0 = 1'b1;
    HREADYOUT_M1 = 1'b1;
    HRESP_OUT    = RESP_OKAY;
    HRDATA_OUT   = '0;
    case (r_data_owner)
      OWN_M0: begin
        HWDATA_S     = HWDATA_M0;
        HREADYOUT_M0 = HREADYOUT_S;
        HRESP_OUT    = HRESP_S;
        HRDATA_OUT   = HRDATA_S;
      end
      OWN_M1: begin
        HWDATA_S     = HWDATA_M1;
        HREADYOUT_M1 = HREADYOUT_S;
        HRESP_OUT    = HRESP_S;
        HRDATA_OUT   = HRDATA_S;
      end
      default: ;
    endcase
  end

endmodule
